sync_fifo_mwsr: RTL and testbench

- Synchronous width up-converting FIFO: multiple narrow writes, single wide read.
- Packs RATIO consecutive W_WIDTH-bit writes into one R_WIDTH-bit entry. The first-written word lands in the least-significant lane.
- Sits on the opposite side of the wide-to-narrow FIFO in the MEL datapath. It re-assembles narrow sample streams into wide words for downstream wide consumers.

---
 rtl/sync_fifo_mwsr.sv | 120 ++++++++++++
 tb/tb_sync_fifo_mwsr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_mwsr.sv
// Width up-converting FIFO: RATIO narrow writes pack LSB-first into one wide entry.
// Define SYNC_FIFO_MWSR_FLUSH_EN to add a flush input that zero-pads a pending partial entry.
module sync_fifo_mwsr #(
    parameter int unsigned W_WIDTH      = 16,
    parameter int unsigned R_WIDTH      = 32,
    parameter int unsigned R_DEPTH      = 8,
    parameter int unsigned R_ADDR_WIDTH = $clog2(R_DEPTH),
    parameter int unsigned W_DEPTH      = R_DEPTH * R_WIDTH / W_WIDTH,
    parameter int unsigned W_ADDR_WIDTH = $clog2(W_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [W_WIDTH-1:0]      wr_data,
    output logic                    full,
    input  logic                    rd_en,
    output logic [R_WIDTH-1:0]      rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic [R_ADDR_WIDTH:0]   rd_count
`ifdef SYNC_FIFO_MWSR_FLUSH_EN
    ,
    input  logic                    flush
`endif
);

    localparam int unsigned RATIO     = R_WIDTH / W_WIDTH;
    localparam int unsigned LANE_BITS = $clog2(RATIO);
    localparam int unsigned PW        = W_ADDR_WIDTH + 1;
    localparam int unsigned QW        = R_ADDR_WIDTH + 1;

    logic [R_WIDTH-1:0]      mem_q [R_DEPTH];

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [QW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [R_WIDTH-1:0]      rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [PW-1:0]           occ;
    logic                    wr_acc, rd_acc;
    logic [LANE_BITS-1:0]    wr_lane;
    logic [R_ADDR_WIDTH-1:0] wr_entry, rd_entry;
    logic [RATIO-1:0]        lane_we;
    logic [R_WIDTH-1:0]      lane_wdata;
`ifdef SYNC_FIFO_MWSR_FLUSH_EN
    logic [PW-LANE_BITS-1:0] pad_entry;
`endif

    // Occupancy in narrow-word units; the read pointer is scaled by RATIO.
    assign occ      = wr_ptr_q - {rd_ptr_q, {LANE_BITS{1'b0}}};
    assign rd_count = occ[PW-1:LANE_BITS];
    assign full     = (occ == PW'(W_DEPTH));
    assign empty    = (rd_count == '0);

    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;
    assign wr_lane  = wr_ptr_q[LANE_BITS-1:0];
    assign wr_entry = wr_ptr_q[W_ADDR_WIDTH-1:LANE_BITS];
    assign rd_entry = rd_ptr_q[R_ADDR_WIDTH-1:0];

    always_comb begin
        lane_we    = '0;
        lane_wdata = '0;
        wr_ptr_d   = wr_ptr_q + PW'(wr_acc);
`ifdef SYNC_FIFO_MWSR_FLUSH_EN
        pad_entry  = '0;
`endif
        for (int unsigned l = 0; l < RATIO; l++) begin
            if (wr_acc && (wr_lane == LANE_BITS'(l))) begin
                lane_we[l]                        = 1'b1;
                lane_wdata[l*W_WIDTH +: W_WIDTH]  = wr_data;
            end
        end
`ifdef SYNC_FIFO_MWSR_FLUSH_EN
        // Padding is judged after the same-cycle write, so it only zeros the
        // lanes above that word and never spills into the next entry.
        if (flush && !full && (wr_ptr_d[LANE_BITS-1:0] != '0)) begin
            for (int unsigned l = 0; l < RATIO; l++) begin
                if (LANE_BITS'(l) >= wr_ptr_d[LANE_BITS-1:0]) begin
                    lane_we[l] = 1'b1;
                end
            end
            pad_entry = wr_ptr_d[PW-1:LANE_BITS] + (PW-LANE_BITS)'(1);
            wr_ptr_d  = {pad_entry, {LANE_BITS{1'b0}}};
        end
`endif
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q + QW'(rd_acc);
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem_q[rd_entry] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < RATIO; l++) begin
            if (rst_n && lane_we[l]) begin
                mem_q[wr_entry][l*W_WIDTH +: W_WIDTH] <= lane_wdata[l*W_WIDTH +: W_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_mwsr.sv
// Self-checking bench for sync_fifo_mwsr against a narrow-word queue model.
module tb_sync_fifo_mwsr;

    localparam int unsigned W_WIDTH = 16;
    localparam int unsigned R_WIDTH = 32;
    localparam int unsigned R_DEPTH = 8;
    localparam int unsigned RATIO   = R_WIDTH / W_WIDTH;
    localparam int unsigned W_DEPTH = R_DEPTH * RATIO;
    localparam int unsigned RCW     = $clog2(R_DEPTH) + 1;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               wr_en   = 1'b0;
    logic               rd_en   = 1'b0;
    logic               flush   = 1'b0;
    logic [W_WIDTH-1:0] wr_data = '0;
    logic               full, empty, rd_valid;
    logic [R_WIDTH-1:0] rd_data;
    logic [RCW-1:0]     rd_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: accepted narrow words in arrival order.
    logic [W_WIDTH-1:0] mq[$];
    logic [R_WIDTH-1:0] m_rd_data  = '0;
    logic               m_rd_valid = 1'b0;

    sync_fifo_mwsr #(
        .W_WIDTH (W_WIDTH),
        .R_WIDTH (R_WIDTH),
        .R_DEPTH (R_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .rd_count (rd_count)
`ifdef SYNC_FIFO_MWSR_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        chk("rd_data",  64'(rd_data),  64'(m_rd_data));
        chk("empty",    64'(empty),    64'(mq.size() < RATIO));
        chk("full",     64'(full),     64'(mq.size() == W_DEPTH));
        chk("rd_count", 64'(rd_count), 64'(mq.size() / RATIO));
    endtask

    // Drive one clock of stimulus, advance the model, then check all outputs.
    task automatic cycle(input logic r, input logic w, input logic [W_WIDTH-1:0] d,
                         input logic rd, input logic fl);
        logic m_full, m_empty, wacc, racc;
        rst_n   = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        flush   = fl;
        m_full  = (mq.size() == W_DEPTH);
        m_empty = (mq.size() < RATIO);
        @(posedge clk);
        #1;
        wacc = w && !m_full;
        racc = rd && !m_empty;
        m_rd_valid = 1'b0;
        if (!r) begin
            mq.delete();
            m_rd_data = '0;
        end else begin
            if (racc) begin
                m_rd_data = '0;
                for (int i = 0; i < int'(RATIO); i++)
                    m_rd_data[i*W_WIDTH +: W_WIDTH] = mq.pop_front();
                m_rd_valid = 1'b1;
            end
            if (wacc) mq.push_back(d);
`ifdef SYNC_FIFO_MWSR_FLUSH_EN
            if (fl && !m_full)
                while ((mq.size() % RATIO) != 0) mq.push_back('0);
`endif
        end
        check_outputs();
    endtask

    initial begin
        int unsigned k;
        int unsigned nreads;
        logic [R_WIDTH-1:0] ew;

        // Reset and basic packing
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0);
        chk("t1_rd_count", 64'(rd_count), 64'd2);
        chk("t1_empty", 64'(empty), 64'd0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t1_first", 64'(rd_data), 64'h22221111);
        chk("t1_valid", 64'(rd_valid), 64'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t1_second", 64'(rd_data), 64'h44443333);

        // Fill to capacity, overflow write dropped
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < int'(W_DEPTH); i++)
            cycle(1'b1, 1'b1, W_WIDTH'(16'h0100 + i), 1'b0, 1'b0);
        chk("t2_full", 64'(full), 64'd1);
        cycle(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("t2_full_hold", 64'(full), 64'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t2_first", 64'(rd_data), 64'h01010100);
        chk("t2_full_clr", 64'(full), 64'd0);
        for (int i = 1; i < int'(R_DEPTH); i++)
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t2_last", 64'(rd_data), 64'h010F010E);
        chk("t2_empty", 64'(empty), 64'd1);

        // Partial entry keeps empty asserted; read while empty is dropped
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
        chk("t3_empty", 64'(empty), 64'd1);
        chk("t3_count", 64'(rd_count), 64'd0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t3_no_valid", 64'(rd_valid), 64'd0);
        chk("t3_data_hold", 64'(rd_data), 64'd0);

        // Steady stream across pointer wrap
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        k = 1;
        nreads = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b1, 1'b1, W_WIDTH'(c + 1), 1'((c % 2) == 1), 1'b0);
            if (rd_valid) begin
                ew = {W_WIDTH'(k + 1), W_WIDTH'(k)};
                chk("t4_seq", 64'(rd_data), 64'(ew));
                k += 2;
                nreads++;
            end
        end
        chk("t4_nreads", 64'(nreads), 64'd19);

        // Mid-stream reset with 3 entries plus a partial pending
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            cycle(1'b1, 1'b1, W_WIDTH'(16'h0A00 + i), 1'b0, 1'b0);
        chk("t5_pre_count", 64'(rd_count), 64'd3);
        cycle(1'b0, 1'b1, 16'h7777, 1'b1, 1'b0);
        chk("t5_empty", 64'(empty), 64'd1);
        chk("t5_full", 64'(full), 64'd0);
        chk("t5_count", 64'(rd_count), 64'd0);
        chk("t5_rd_data", 64'(rd_data), 64'd0);
        cycle(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h6666, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t5_after", 64'(rd_data), 64'h66665555);

`ifdef SYNC_FIFO_MWSR_FLUSH_EN
        // Flush pads a partial entry with zeros
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("t7_empty", 64'(empty), 64'd0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t7_beef", 64'(rd_data), 64'h0000BEEF);
        cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("t7_1234", 64'(rd_data), 64'h00001234);
`endif

        // Randomized traffic, biased so both full and empty are reached
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            logic w, rd, r, fl;
            int unsigned bias;
            bias = (i / 100) % 2 == 0 ? 3 : 1;
            w  = ($urandom_range(0, 3) < bias);
            rd = ($urandom_range(0, 3) >= bias);
            r  = ($urandom_range(0, 63) != 0);
            fl = ($urandom_range(0, 15) == 0);
            cycle(r, w, W_WIDTH'($urandom()), rd, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
